// File: rtl/io_tile_pkg.sv
// Shared definitions for the io tiles: debounce state encoding, pad reset level
// and default debounce counter width.
package io_tile_pkg;

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } pad_state_t;

  localparam logic IO_PAD_RESET_LEVEL = 1'b0;
  localparam int   DEFAULT_DEBOUNCE_W = 8;

endpackage

// File: rtl/io_pad_sync_chain.sv
// Plain flop chain that brings an asynchronous pad into the clk domain.
module io_pad_sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/logical_tile_io_input_pad_conditioner.sv
// GPIN receive tile: synchronizes and debounces the pad, drives the clean level
// to the fabric and reports each committed edge through a one-entry event buffer.
//
// Event handshake: an event is offered while evt_valid = 1 and is consumed on any
// clk edge where evt_valid & evt_ready; evt_valid/evt_rise/evt_overflow are
// registered and never depend combinationally on evt_ready.
module logical_tile_io_input_pad_conditioner
  import io_tile_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE_W  = DEFAULT_DEBOUNCE_W,
  parameter logic RESET_LEVEL = IO_PAD_RESET_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gfpga_pad_GPIN_PAD,
  input  logic [DEBOUNCE_W-1:0] cfg_debounce_len,
  input  logic                  cfg_bypass,
  output logic                  io_input_inpad,
  output logic                  evt_valid,
  output logic                  evt_rise,
  input  logic                  evt_ready,
  output logic                  evt_overflow,
  input  logic                  ovf_clear,
  output logic                  dbg_state
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = {DEBOUNCE_W{1'b1}};
  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  logic                  sync_out;
  logic                  level;
  pad_state_t            state;
  logic [DEBOUNCE_W-1:0] cnt;
  logic                  commit;
  logic                  new_level;
  logic                  pop;

  io_pad_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gfpga_pad_GPIN_PAD),
    .q     (sync_out)
  );

  // The stability window is the cfg_debounce_len + 1 samples seen up to the
  // cycle cnt reaches the length; the commit edge itself does not re-sample.
  always_comb begin
    commit    = 1'b0;
    new_level = level;
    if (cfg_bypass) begin
      if (sync_out != level) begin
        commit    = 1'b1;
        new_level = sync_out;
      end
    end else if (state == CANDIDATE && cnt >= cfg_debounce_len) begin
      commit    = 1'b1;
      new_level = ~level;
    end
  end

  assign pop = evt_valid & evt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level        <= RESET_LEVEL;
      state        <= STABLE;
      cnt          <= '0;
      evt_valid    <= 1'b0;
      evt_rise     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      level <= new_level;

      if (cfg_bypass) begin
        state <= STABLE;
        cnt   <= '0;
      end else begin
        case (state)
          STABLE: begin
            if (sync_out != level) begin
              state <= CANDIDATE;
              cnt   <= '0;
            end
          end
          CANDIDATE: begin
            if (commit || sync_out == level) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end

      // Oldest event is kept on overflow; a set beats a simultaneous clear.
      if (commit && (!evt_valid || pop)) begin
        evt_valid <= 1'b1;
        evt_rise  <= new_level;
      end else if (pop) begin
        evt_valid <= 1'b0;
      end

      if (commit && evt_valid && !pop) begin
        evt_overflow <= 1'b1;
      end else if (ovf_clear) begin
        evt_overflow <= 1'b0;
      end
    end
  end

  assign io_input_inpad = level;
  assign dbg_state      = state;

endmodule

// File: tb/tb_logical_tile_io_input_pad_conditioner.sv
// Bench for the GPIN pad conditioner: directed scenarios with a queue of
// expected event polarities consumed whenever the DUT hands off an event.
module tb_logical_tile_io_input_pad_conditioner;

  logic       clk;
  logic       rst_n;
  logic       pad;
  logic [7:0] len;
  logic       bypass;
  logic       inpad;
  logic       evt_valid;
  logic       evt_rise;
  logic       evt_ready;
  logic       evt_overflow;
  logic       ovf_clear;
  logic       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  logical_tile_io_input_pad_conditioner dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .gfpga_pad_GPIN_PAD (pad),
    .cfg_debounce_len   (len),
    .cfg_bypass         (bypass),
    .io_input_inpad     (inpad),
    .evt_valid          (evt_valid),
    .evt_rise           (evt_rise),
    .evt_ready          (evt_ready),
    .evt_overflow       (evt_overflow),
    .ovf_clear          (ovf_clear),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_level(input logic exp, input int budget, input string tag);
    int n = 0;
    while (inpad !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, inpad}, {31'd0, exp});
  endtask

  // scoreboard: a handshake at the coming posedge consumes one expected event
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", 32'd1, 32'd0);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("evt_rise_sb", {31'd0, evt_rise}, {31'd0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0; pad = 1'b1; len = 8'd3; bypass = 1'b0;
    evt_ready = 1'b0; ovf_clear = 1'b0;

    // reset with pad high, then first rise after 7 edges
    tick(3);
    check("rst_inpad", {31'd0, inpad}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_ovf", {31'd0, evt_overflow}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick(6);
    check("lat_edge6", {31'd0, inpad}, 32'd0);
    tick(1);
    check("lat_edge7", {31'd0, inpad}, 32'd1);
    check("lat_valid", {31'd0, evt_valid}, 32'd1);
    check("lat_rise", {31'd0, evt_rise}, 32'd1);
    exp_q.push_back(1'b1);
    evt_ready = 1'b1;
    tick(2);
    check("lat_popped", {31'd0, evt_valid}, 32'd0);

    // glitch rejection
    exp_q.push_back(1'b0);
    pad = 1'b0;
    wait_level(1'b0, 20, "glitch_pre_low");
    tick(5);
    pad = 1'b1; tick(3); pad = 1'b0;
    tick(15);
    check("glitch3_inpad", {31'd0, inpad}, 32'd0);
    check("glitch3_valid", {31'd0, evt_valid}, 32'd0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    pad = 1'b1; tick(4); pad = 1'b0;
    wait_level(1'b1, 10, "pulse4_rise");
    wait_level(1'b0, 15, "pulse4_fall");
    tick(3);

    // back-pressure and overflow
    evt_ready = 1'b0; len = 8'd0;
    pad = 1'b1; tick(10);
    pad = 1'b0; tick(10);
    check("bp_valid", {31'd0, evt_valid}, 32'd1);
    check("bp_rise_kept", {31'd0, evt_rise}, 32'd1);
    check("bp_ovf", {31'd0, evt_overflow}, 32'd1);
    check("bp_inpad", {31'd0, inpad}, 32'd0);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("bp_ovf_clr", {31'd0, evt_overflow}, 32'd0);
    check("bp_valid_held", {31'd0, evt_valid}, 32'd1);
    exp_q.push_back(1'b1);
    evt_ready = 1'b1; tick(2); evt_ready = 1'b0;
    check("bp_drained", {31'd0, evt_valid}, 32'd0);

    // pop and load in the same cycle
    pad = 1'b1; tick(4);
    check("pp_inpad_hi", {31'd0, inpad}, 32'd1);
    check("pp_valid_hi", {31'd0, evt_valid}, 32'd1);
    pad = 1'b0; tick(3);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    evt_ready = 1'b1; tick();
    check("pp_valid", {31'd0, evt_valid}, 32'd1);
    check("pp_rise_new", {31'd0, evt_rise}, 32'd0);
    check("pp_ovf", {31'd0, evt_overflow}, 32'd0);
    check("pp_inpad", {31'd0, inpad}, 32'd0);
    tick(2);

    // overflow set beats clear in the same cycle
    evt_ready = 1'b0;
    pad = 1'b1; tick(4);
    pad = 1'b0; tick(3);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("ovf_set_wins", {31'd0, evt_overflow}, 32'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("ovf_cleared", {31'd0, evt_overflow}, 32'd0);
    exp_q.push_back(1'b1);
    evt_ready = 1'b1; tick(2);

    // bypass: follow each toggle after 3 edges
    bypass = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic old_lvl;
      old_lvl = pad;
      pad = ~pad;
      exp_q.push_back(pad);
      tick(2);
      check("byp_old", {31'd0, inpad}, {31'd0, old_lvl});
      tick(1);
      check("byp_new", {31'd0, inpad}, {31'd0, pad});
      tick(2);
    end
    bypass = 1'b0;
    tick(3);

    // reset mid-candidate discards the change
    len = 8'd200;
    pad = 1'b1; tick(50);
    check("mr_state_cand", {31'd0, dbg_state}, 32'd1);
    rst_n = 1'b0; pad = 1'b0; tick(2);
    check("mr_inpad", {31'd0, inpad}, 32'd0);
    check("mr_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1; tick(10);
    check("mr_after_inpad", {31'd0, inpad}, 32'd0);
    check("mr_after_valid", {31'd0, evt_valid}, 32'd0);

    // reset drops a buffered event without overflow
    evt_ready = 1'b0; len = 8'd0;
    pad = 1'b1; tick(6);
    check("rb_valid", {31'd0, evt_valid}, 32'd1);
    rst_n = 1'b0; pad = 1'b0; tick();
    check("rb_valid_drop", {31'd0, evt_valid}, 32'd0);
    check("rb_ovf", {31'd0, evt_overflow}, 32'd0);
    rst_n = 1'b1; evt_ready = 1'b1; tick(5);

    // live length change: cnt = 40, len lowered to 10 commits next edge
    len = 8'd200;
    pad = 1'b1; tick(43);
    check("live_pre_inpad", {31'd0, inpad}, 32'd0);
    check("live_pre_state", {31'd0, dbg_state}, 32'd1);
    exp_q.push_back(1'b1);
    len = 8'd10; tick();
    check("live_commit", {31'd0, inpad}, 32'd1);
    exp_q.push_back(1'b0);
    pad = 1'b0;
    wait_level(1'b0, 20, "live_fall");
    tick(4);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
